alu_op_pipe: RTL

Registered, flow-controlled operation pipeline that sits directly upstream of the system's result consumers. It accepts opcode/operand pairs over a valid/ready handshake, executes them in a combinational ALU datapath, and buffers tagged results in a small FIFO, so downstream backpressure never corrupts or drops an operation. It also keeps a running count of retired operations.

---
 rtl/alu_pipe_pkg.sv | 25 ++
 rtl/alu_exec.sv | 44 ++++
 rtl/alu_op_pipe.sv | 123 ++++++++++++
 3 files changed

// File: rtl/alu_pipe_pkg.sv
// Shared types for the ALU operation pipeline: opcode encoding and the
// tagged result record stored in the result FIFO.
package alu_pipe_pkg;

  localparam int DATA_W = 16;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_AND  = 3'b010,
    OP_OR   = 3'b011,
    OP_XOR  = 3'b100,
    OP_NOT  = 3'b101,
    OP_ILL6 = 3'b110,
    OP_ILL7 = 3'b111
  } opcode_t;

  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic              zero;
    logic              carry;
    logic              illegal;
  } alu_res_t;

endpackage

// File: rtl/alu_exec.sv
// Combinational ALU: maps opcode and operands to a result record with
// zero/carry/illegal flags.
module alu_exec
  import alu_pipe_pkg::*;
(
  input  opcode_t           op_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output alu_res_t          res_o
);

  logic [DATA_W:0]   sum;
  logic [DATA_W-1:0] result;
  logic              carry;
  logic              illegal;

  always_comb begin
    sum     = {1'b0, a_i} + {1'b0, b_i};
    result  = '0;
    carry   = 1'b0;
    illegal = 1'b0;
    unique case (op_i)
      OP_ADD: begin
        result = sum[DATA_W-1:0];
        carry  = sum[DATA_W];
      end
      // Carry on SUB reports an unsigned borrow.
      OP_SUB: begin
        result = a_i - b_i;
        carry  = (a_i < b_i);
      end
      OP_AND:  result = a_i & b_i;
      OP_OR:   result = a_i | b_i;
      OP_XOR:  result = a_i ^ b_i;
      OP_NOT:  result = ~a_i;
      default: illegal = 1'b1;
    endcase
    res_o.result  = result;
    res_o.zero    = (result == '0);
    res_o.carry   = carry;
    res_o.illegal = illegal;
  end

endmodule

// File: rtl/alu_op_pipe.sv
// Flow-controlled ALU pipeline: one operand stage feeding the ALU, a small
// circular result FIFO absorbing downstream backpressure, and a retire counter.
module alu_op_pipe #(
  parameter int DATA_W     = alu_pipe_pkg::DATA_W,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_opcode,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic              out_zero,
  output logic              out_carry,
  output logic              out_illegal,
  output logic [15:0]       op_count
);

  import alu_pipe_pkg::*;

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]   DEPTH_C = FIFO_DEPTH[AW:0];
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);

  logic              s1_valid_q, s1_valid_d;
  opcode_t           s1_op_q, s1_op_d;
  logic [DATA_W-1:0] s1_a_q, s1_a_d;
  logic [DATA_W-1:0] s1_b_q, s1_b_d;
  alu_res_t          s1_res;

  alu_res_t          mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic [15:0]       op_count_q, op_count_d;

  logic              pop;
  logic              s1_fire;
  logic              accept;
  alu_res_t          head;

  alu_exec u_exec (
    .op_i  (s1_op_q),
    .a_i   (s1_a_q),
    .b_i   (s1_b_q),
    .res_o (s1_res)
  );

  // A pop in the same cycle frees a slot, so S1 may drain into a full FIFO.
  assign pop      = (count_q != '0) && out_ready;
  assign s1_fire  = s1_valid_q && ((count_q < DEPTH_C) || pop);
  assign in_ready = !rst && (!s1_valid_q || s1_fire);
  assign accept   = in_valid && in_ready;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_op_d    = s1_op_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    if (accept) begin
      s1_valid_d = 1'b1;
      s1_op_d    = opcode_t'(in_opcode);
      s1_a_d     = in_a;
      s1_b_d     = in_b;
    end else if (s1_fire) begin
      s1_valid_d = 1'b0;
    end

    wr_ptr_d   = s1_fire ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    op_count_d = pop ? op_count_q + 16'd1 : op_count_q;

    count_d = count_q;
    case ({s1_fire, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= OP_ADD;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      op_count_q <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_op_q    <= s1_op_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      op_count_q <= op_count_d;
    end
  end

  // Storage needs no reset: entries are only visible through count_q.
  always_ff @(posedge clk) begin
    if (s1_fire) begin
      mem_q[wr_ptr_q] <= s1_res;
    end
  end

  assign head        = mem_q[rd_ptr_q];
  assign out_valid   = (count_q != '0);
  assign out_result  = out_valid ? head.result  : '0;
  assign out_zero    = out_valid ? head.zero    : 1'b0;
  assign out_carry   = out_valid ? head.carry   : 1'b0;
  assign out_illegal = out_valid ? head.illegal : 1'b0;
  assign op_count    = op_count_q;

endmodule
